mux4x1_rr_arbiter: RTL and testbench



---
 rtl/mux4x1_rr_arbiter.sv | 140 ++++++++++++++
 tb/tb_mux4x1_rr_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mux4x1_rr_arbiter.sv
// rtl/mux4x1_rr_arbiter.sv - round-robin arbiter driving 4:1 mux select with bounded hold
//
// Shares one 4:1 multiplexer between four requesters. Requester i owns mux
// input i (0->a, 1->b, 2->c, 3->d). The grant rotates fairly. A contended
// owner keeps the grant for at most MAX_HOLD cycles.
//
// Parameters:
//   MAX_HOLD  max consecutive grant cycles while another request is pending (1..255)
// Ports:
//   clk_i     rising-edge clock
//   rst_ni    asynchronous active-low reset
//   req_i     [3:0] level request vector, bit i = requester i
//   grant_o   [3:0] registered one-hot grant, zero when idle
//   s0_o      registered mux select MSB
//   s1_o      registered mux select LSB ({s0,s1} = granted index)
//   valid_o   registered, high while a grant is active
module mux4x1_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] req_i,
  output logic [3:0] grant_o,
  output logic       s0_o,
  output logic       s1_o,
  output logic       valid_o
);

  localparam int unsigned HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_ONE = HW'(1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e        state_q, state_d;
  logic [1:0]    owner_q, owner_d;
  logic [1:0]    last_q, last_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [3:0]    grant_q, grant_d;
  logic          s0_q, s0_d;
  logic          s1_q, s1_d;
  logic          valid_q, valid_d;

  logic [3:0]    others;

  // First candidate at base+1, base+2, base+3, base+4 (mod 4). Scanning from
  // the farthest offset down lets the nearest set bit win.
  function automatic logic [1:0] rr_pick(input logic [1:0] base, input logic [3:0] cand);
    logic [1:0] idx;
    rr_pick = base;
    for (int k = 4; k >= 1; k--) begin
      idx = base + 2'(k);
      if (cand[idx]) rr_pick = idx;
    end
  endfunction

  // Requests other than the current owner; the owner is excluded on handoff.
  assign others = req_i & ~(4'b0001 << owner_q);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (req_i != 4'b0000) begin
          owner_d = rr_pick(last_q, req_i);
          last_d  = owner_d;
          hold_d  = HOLD_ONE;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!req_i[owner_q]) begin
          // Release: hand off without a bubble, or fall idle.
          if (others != 4'b0000) begin
            owner_d = rr_pick(owner_q, others);
            last_d  = owner_d;
            hold_d  = HOLD_ONE;
          end else begin
            state_d = IDLE;
            hold_d  = '0;
          end
        end else if (hold_q == HOLD_MAX && others != 4'b0000) begin
          // Preempt: owner used up its slot while someone else waits.
          owner_d = rr_pick(owner_q, others);
          last_d  = owner_d;
          hold_d  = HOLD_ONE;
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + HOLD_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are a registered decode of the next state, so the select never
  // depends combinationally on req_i.
  always_comb begin
    grant_d = 4'b0000;
    s0_d    = 1'b0;
    s1_d    = 1'b0;
    valid_d = 1'b0;
    if (state_d == GRANT) begin
      grant_d = 4'b0001 << owner_d;
      s0_d    = owner_d[1];
      s1_d    = owner_d[0];
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      owner_q <= 2'd0;
      last_q  <= 2'd3;
      hold_q  <= '0;
      grant_q <= 4'b0000;
      s0_q    <= 1'b0;
      s1_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      grant_q <= grant_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      valid_q <= valid_d;
    end
  end

  assign grant_o = grant_q;
  assign s0_o    = s0_q;
  assign s1_o    = s1_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_mux4x1_rr_arbiter.sv
// tb/tb_mux4x1_rr_arbiter.sv - scoreboard bench for mux4x1_rr_arbiter
module tb_mux4x1_rr_arbiter;

  localparam int MH = 4;

  logic       clk_i;
  logic       rst_ni;
  logic [3:0] req_i;
  logic [3:0] grant_o;
  logic       s0_o;
  logic       s1_o;
  logic       valid_o;

  mux4x1_rr_arbiter #(.MAX_HOLD(MH)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req_i   (req_i),
    .grant_o (grant_o),
    .s0_o    (s0_o),
    .s1_o    (s1_o),
    .valid_o (valid_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0] grant;
    logic [1:0] sel;
    logic       valid;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: plain integers, arithmetic modulo 4.
  bit m_idle;
  int m_owner;
  int m_last;
  int m_hold;

  function automatic int next_after(int base, logic [3:0] cand);
    for (int k = 1; k <= 4; k++) begin
      if (cand[(base + k) % 4]) return (base + k) % 4;
    end
    return base;
  endfunction

  task automatic model_reset();
    m_idle  = 1'b1;
    m_owner = 0;
    m_last  = 3;
    m_hold  = 0;
  endtask

  task automatic model_step(input logic [3:0] r);
    logic [3:0] oth;
    if (m_idle) begin
      if (r != 4'b0000) begin
        m_owner = next_after(m_last, r);
        m_last  = m_owner;
        m_hold  = 1;
        m_idle  = 1'b0;
      end
    end else begin
      oth = r;
      oth[m_owner] = 1'b0;
      if (!r[m_owner]) begin
        if (oth != 4'b0000) begin
          m_owner = next_after(m_owner, oth);
          m_last  = m_owner;
          m_hold  = 1;
        end else begin
          m_idle = 1'b1;
          m_hold = 0;
        end
      end else if (m_hold == MH && oth != 4'b0000) begin
        m_owner = next_after(m_owner, oth);
        m_last  = m_owner;
        m_hold  = 1;
      end else begin
        m_hold = (m_hold + 1 > MH) ? MH : m_hold + 1;
      end
    end
  endtask

  task automatic drive(input logic [3:0] r);
    exp_t e;
    req_i = r;
    model_step(r);
    e.valid = !m_idle;
    e.grant = m_idle ? 4'b0000 : 4'(1 << m_owner);
    e.sel   = m_idle ? 2'b00 : 2'(m_owner);
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [3:0] r);
    @(negedge clk_i);
    drive(r);
  endtask

  task automatic check_idle_outputs(input string name);
    total++;
    if (grant_o !== 4'b0000 || s0_o !== 1'b0 || s1_o !== 1'b0 || valid_o !== 1'b0) begin
      bad++;
      $display("FAIL %s: got grant=%b sel=%b%b valid=%b, want grant=0000 sel=00 valid=0",
               name, grant_o, s0_o, s1_o, valid_o);
    end
  endtask

  // Monitor: after each rising edge, compare DUT outputs with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (grant_o !== e.grant || {s0_o, s1_o} !== e.sel || valid_o !== e.valid) begin
          bad++;
          $display("FAIL scoreboard t=%0t req=%b: got grant=%b sel=%b%b valid=%b, want grant=%b sel=%b valid=%b",
                   $time, req_i, grant_o, s0_o, s1_o, valid_o, e.grant, e.sel, e.valid);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] r;
    model_reset();
    rst_ni = 1'b0;
    req_i  = 4'b1111;
    repeat (3) @(posedge clk_i);
    #2;
    check_idle_outputs("reset_hold");

    // Release reset: first grant goes to requester 0.
    @(negedge clk_i);
    rst_ni = 1'b1;
    drive(4'b1111);

    // Rotation: each owner drops its bit for the cycle after being granted.
    for (int i = 0; i < 6; i++) begin
      r = 4'b1111;
      if (!m_idle) r[m_owner] = 1'b0;
      step(r);
    end
    step(4'b0000);
    step(4'b0000);

    // Single requester: holds indefinitely, then releases.
    repeat (20) step(4'b0100);
    step(4'b0000);
    step(4'b0000);

    // Preemption between two held requests.
    repeat (20) step(4'b0011);
    step(4'b0000);

    // Late contender after saturation.
    repeat (10) step(4'b0001);
    repeat (3) step(4'b1001);
    step(4'b0000);

    // Asynchronous reset mid-grant.
    repeat (3) step(4'b0100);
    @(posedge clk_i);
    #3;
    rst_ni = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    model_reset();
    @(negedge clk_i);
    req_i = 4'b0101;
    @(negedge clk_i);
    check_idle_outputs("reset_low");
    rst_ni = 1'b1;
    drive(4'b0101);
    step(4'b0000);

    // Randomized phase: requests held for random stretches.
    for (int seg = 0; seg < 120; seg++) begin
      r = 4'($urandom_range(0, 15));
      repeat ($urandom_range(1, 12)) begin
        if ($urandom_range(0, 3) == 0) r[$urandom_range(0, 3)] ^= 1'b1;
        step(r);
      end
    end
    step(4'b0000);

    repeat (3) @(posedge clk_i);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
